// File: rtl/rope_flash_reader.sv
// rtl/rope_flash_reader.sv - core-rope flash read sequencer with last-word buffer (optional ROPE_PARITY_CHECK_EN)
module rope_flash_reader #(
    parameter int SETUP_CYCLES   = 1,
    parameter int ACCESS_CYCLES  = 120,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [16:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_hit,
    output logic        parity_err,
    output logic [16:0] flash_a,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    input  logic [15:0] flash_dq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP,
        S_RECOVER
    } state_t;

    localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] ACCESS_LD  = 8'(ACCESS_CYCLES - 1);
    localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        rsp_hit_q;
    logic        perr_q;
    logic [16:0] flash_a_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        buf_valid_q;
    logic [16:0] buf_addr_q;
    logic [15:0] buf_data_q;

    // Parity status of the word being captured and of the buffered word
    logic        cap_perr;
    logic        buf_perr;

`ifdef ROPE_PARITY_CHECK_EN
    assign cap_perr = ~^flash_dq;
    assign buf_perr = ~^buf_data_q;
`else
    assign cap_perr = 1'b0;
    assign buf_perr = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_hit    = rsp_hit_q;
    assign parity_err = perr_q;
    assign flash_a    = flash_a_q;
    assign flash_ce_n = ce_n_q;
    assign flash_oe_n = oe_n_q;
    assign flash_we_n = 1'b1;

    // Read sequencer: accept, buffer lookup, strobe timing, response hold, recovery
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_hit_q   <= 1'b0;
            perr_q      <= 1'b0;
            flash_a_q   <= 17'd0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 17'd0;
            buf_data_q  <= 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_ready_q && req_valid) begin
                        req_ready_q <= 1'b0;
                        if (buf_valid_q && (req_addr == buf_addr_q)) begin
                            // rsp_valid follows one edge later, raised in S_RESP
                            rsp_data_q <= buf_data_q;
                            rsp_hit_q  <= 1'b1;
                            perr_q     <= buf_perr;
                            state_q    <= S_RESP;
                        end else begin
                            flash_a_q <= req_addr;
                            cnt_q     <= SETUP_LD;
                            state_q   <= S_SETUP;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 8'd0) begin
                        ce_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        cnt_q   <= ACCESS_LD;
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == 8'd0) begin
                        rsp_data_q  <= flash_dq;
                        rsp_hit_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        perr_q      <= cap_perr;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        // A word with bad parity must never be replayed from the buffer
                        buf_valid_q <= ~cap_perr;
                        buf_addr_q  <= flash_a_q;
                        buf_data_q  <= flash_dq;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_hit_q) begin
                            req_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            cnt_q   <= RECOVER_LD;
                            state_q <= S_RECOVER;
                        end
                    end
                end
                S_RECOVER: begin
                    if (cnt_q == 8'd0) begin
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rope_flash_reader.sv
// tb/tb_rope_flash_reader.sv - directed self-checking bench for rope_flash_reader
module tb_rope_flash_reader;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [16:0] req_addr = 17'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_hit;
    logic        parity_err;
    logic [16:0] flash_a;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic [15:0] flash_dq = 16'd0;

    int n_checks = 0;
    int n_fail   = 0;

    rope_flash_reader dut (
        .SIM_CLK    (SIM_CLK),
        .SIM_RST    (SIM_RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_hit    (rsp_hit),
        .parity_err (parity_err),
        .flash_a    (flash_a),
        .flash_ce_n (flash_ce_n),
        .flash_oe_n (flash_oe_n),
        .flash_we_n (flash_we_n),
        .flash_dq   (flash_dq)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    task automatic step();
        @(posedge SIM_CLK);
        #1;
    endtask

    // Issue one read with rsp_ready high; lat is edges from accept to rsp_valid (-1 if none)
    task automatic read_word(input logic [16:0] a, input logic [15:0] dq, output int lat,
                             output logic [15:0] d, output logic h, output logic pe, output int ce_lo);
        int w;
        lat = -1; ce_lo = 0; d = 16'd0; h = 1'b0; pe = 1'b0;
        flash_dq = dq;
        rsp_ready = 1'b1;
        w = 0;
        while (!req_ready && w < 400) begin
            step();
            w++;
        end
        if (!req_ready) return;
        req_addr = a;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 1; k <= 300 && lat < 0; k++) begin
            step();
            if (!flash_ce_n) ce_lo++;
            if (rsp_valid) begin
                lat = k; d = rsp_data; h = rsp_hit; pe = parity_err;
            end
        end
    endtask

    task automatic test_reset();
        SIM_RST = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_hit, parity_err, flash_a, flash_ce_n, flash_oe_n, flash_we_n}
            !== {1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 17'd0, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h hit=%b perr=%b a=%h ce=%b oe=%b we=%b required 0 0 0000 0 0 00000 1 1 1",
                     req_ready, rsp_valid, rsp_data, rsp_hit, parity_err, flash_a, flash_ce_n, flash_oe_n, flash_we_n);
        end
        SIM_RST = 1'b0;
        step();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_rise: got %b required 1", req_ready);
        end
    endtask

    task automatic test_miss();
        int lat, ce_lo; logic [15:0] d; logic h, pe;
        read_word(17'h00010, 16'h8001, lat, d, h, pe, ce_lo);
        n_checks++;
        if (lat !== 121) begin n_fail++; $display("FAIL miss_latency: got %0d required 121", lat); end
        n_checks++;
        if (ce_lo !== 120) begin n_fail++; $display("FAIL miss_ce_low_cycles: got %0d required 120", ce_lo); end
        n_checks++;
        if (d !== 16'h8001) begin n_fail++; $display("FAIL miss_data: got %h required 8001", d); end
        n_checks++;
        if (h !== 1'b0) begin n_fail++; $display("FAIL miss_hit_flag: got %b required 0", h); end
        n_checks++;
        if (flash_a !== 17'h00010) begin n_fail++; $display("FAIL miss_flash_a: got %h required 00010", flash_a); end
    endtask

    task automatic test_hit();
        int lat, ce_lo; logic [15:0] d; logic h, pe;
        read_word(17'h00010, 16'hFFFF, lat, d, h, pe, ce_lo);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d required 1", lat); end
        n_checks++;
        if (h !== 1'b1) begin n_fail++; $display("FAIL hit_flag: got %b required 1", h); end
        n_checks++;
        if (d !== 16'h8001) begin n_fail++; $display("FAIL hit_data: got %h required 8001", d); end
        n_checks++;
        if (ce_lo !== 0) begin n_fail++; $display("FAIL hit_no_strobe: ce low %0d cycles required 0", ce_lo); end
    endtask

    task automatic test_stall();
        int w;
        w = 0;
        while (!req_ready && w < 400) begin step(); w++; end
        flash_dq = 16'h1234;
        rsp_ready = 1'b0;
        req_addr = 17'h00020;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 300) begin step(); w++; end
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_timeout: rsp_valid %b required 1", rsp_valid); end
        for (int k = 1; k <= 10; k++) begin
            flash_dq = 16'h1234 ^ 16'(k * 16'h0F0F);
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: vld=%b data=%h required 1 1234", k, rsp_valid, rsp_data);
            end
        end
        rsp_ready = 1'b1;
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_handshake: vld=%b rdy=%b required 0 0", rsp_valid, req_ready);
        end
        step();
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_recover1: rdy=%b required 0", req_ready); end
        step();
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_recover2: rdy=%b required 1", req_ready); end
    endtask

    task automatic test_reset_mid_access();
        int w, lat, ce_lo; logic [15:0] d; logic h, pe;
        w = 0;
        while (!req_ready && w < 400) begin step(); w++; end
        flash_dq = 16'h5A5B;
        req_addr = 17'h00030;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (50) step();
        n_checks++;
        if (flash_ce_n !== 1'b0) begin n_fail++; $display("FAIL midreset_in_access: ce=%b required 0", flash_ce_n); end
        SIM_RST = 1'b1;
        step();
        n_checks++;
        if (flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ce=%b oe=%b vld=%b rdy=%b required 1 1 0 0", flash_ce_n, flash_oe_n, rsp_valid, req_ready);
        end
        SIM_RST = 1'b0;
        read_word(17'h00020, 16'h1234, lat, d, h, pe, ce_lo);
        n_checks++;
        if (lat !== 121 || h !== 1'b0 || ce_lo !== 120) begin
            n_fail++;
            $display("FAIL midreset_buffer_invalid: lat=%0d hit=%b ce_lo=%0d required 121 0 120", lat, h, ce_lo);
        end
    endtask

    task automatic test_parity();
        int lat, ce_lo; logic [15:0] d; logic h, pe;
        read_word(17'h00040, 16'h0003, lat, d, h, pe, ce_lo);
`ifdef ROPE_PARITY_CHECK_EN
        n_checks++;
        if (lat !== 121 || pe !== 1'b1) begin n_fail++; $display("FAIL parity_bad_word: lat=%0d perr=%b required 121 1", lat, pe); end
        read_word(17'h00040, 16'h0003, lat, d, h, pe, ce_lo);
        n_checks++;
        if (lat !== 121 || h !== 1'b0) begin n_fail++; $display("FAIL parity_bad_not_buffered: lat=%0d hit=%b required 121 0", lat, h); end
        read_word(17'h00050, 16'h0007, lat, d, h, pe, ce_lo);
        n_checks++;
        if (lat !== 121 || pe !== 1'b0) begin n_fail++; $display("FAIL parity_good_word: lat=%0d perr=%b required 121 0", lat, pe); end
        read_word(17'h00050, 16'h0007, lat, d, h, pe, ce_lo);
        n_checks++;
        if (lat !== 1 || h !== 1'b1 || d !== 16'h0007) begin
            n_fail++; $display("FAIL parity_good_buffered: lat=%0d hit=%b data=%h required 1 1 0007", lat, h, d);
        end
`else
        n_checks++;
        if (lat !== 121 || pe !== 1'b0 || d !== 16'h0003) begin
            n_fail++; $display("FAIL noparity_word: lat=%0d perr=%b data=%h required 121 0 0003", lat, pe, d);
        end
        read_word(17'h00040, 16'h0000, lat, d, h, pe, ce_lo);
        n_checks++;
        if (lat !== 1 || h !== 1'b1 || d !== 16'h0003 || pe !== 1'b0) begin
            n_fail++; $display("FAIL noparity_rehit: lat=%0d hit=%b data=%h perr=%b required 1 1 0003 0", lat, h, d, pe);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_stall();
        test_reset_mid_access();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rope_flash_reader.md
# rope_flash_reader

Read sequencer directly upstream of the SST39VF200A core-rope flash model. It accepts 17-bit word-read requests from the AGC fixed-memory side, drives the flash address and CE_n/OE_n strobes with programmable setup, access and recovery windows, and captures DQ[15:0]. The result is returned over a valid/ready response port. A one-entry last-word buffer answers repeated reads of the same address without touching the flash.

## Interface
Parameters:
- SETUP_CYCLES, 1: cycles the address is driven with CE_n high before the strobes assert; range 1..255.
- ACCESS_CYCLES, 120: cycles CE_n/OE_n are held low before DQ is sampled; range 1..255. The default covers the FPGA serial-flash path.
- RECOVER_CYCLES, 2: cycles CE_n is held high after a flash access, so the flash returns to its deselected state; range 1..255.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- SIM_CLK  in  1  clock.
- SIM_RST  in  1  synchronous active-high reset.
- req_valid  in  1  read request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  17  word address; sampled on accept.
- rsp_valid  out  1  response word present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  16  returned word.
- rsp_hit  out  1  response was served from the last-word buffer.
- parity_err  out  1  odd-parity failure on rsp_data; constant 0 without the macro.
- flash_a  out  17  to A16..A0.
- flash_ce_n  out  1  to CE_n.
- flash_oe_n  out  1  to OE_n.
- flash_we_n  out  1  to WE_n; constant 1.
- flash_dq  in  16  from DQ15..DQ0.

## Operation
- States: IDLE, SETUP, ACCESS, RESP, RECOVER.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_hit=0, parity_err=0, flash_a=0, flash_ce_n=1, flash_oe_n=1, flash_we_n=1. The buffer is invalid and the state is IDLE. req_ready rises on the first cycle after SIM_RST falls.
- req_ready=1 only in IDLE. A request is accepted on any edge where req_valid && req_ready.
- Hit path: the buffer is valid and req_addr equals the stored address.
  - Go to RESP with rsp_data = stored word and rsp_hit=1.
  - No strobe activity and no RECOVER.
- Miss path:
  - Latch req_addr into flash_a and go to SETUP. flash_a holds this value until the next miss is accepted.
  - SETUP: count SETUP_CYCLES, then assert flash_ce_n=0 and flash_oe_n=0 and go to ACCESS.
  - ACCESS: count ACCESS_CYCLES. On the final edge:
    - capture flash_dq into rsp_data;
    - deassert both strobes;
    - set rsp_hit=0;
    - load the buffer (address and word; valid=1);
    - go to RESP.
- RESP: rsp_valid=1, and rsp_data/rsp_hit/parity_err stay stable until rsp_ready. On the handshake edge, go to RECOVER (miss) or IDLE (hit).
- RECOVER: CE_n high for RECOVER_CYCLES, then IDLE.
- Counter: 8-bit down-counter loaded with N-1; the state exits when it reads 0.
- SIM_RST asserted in any state returns every output to its reset value on that edge. This includes driving CE_n/OE_n high mid-access. The buffer is invalidated and any pending response is discarded.

## Timing
- Accept edge = cycle 0.
- Miss:
  - CE_n/OE_n low from edge SETUP_CYCLES to edge SETUP_CYCLES+ACCESS_CYCLES.
  - DQ is sampled at edge SETUP_CYCLES+ACCESS_CYCLES.
  - rsp_valid is high from that same edge, i.e. SETUP+ACCESS cycles after accept.
- Hit: rsp_valid is high from edge 1.
- Earliest next accept after the response handshake:
  - 1 cycle when the response was a hit;
  - RECOVER_CYCLES+1 cycles when it was a miss.
- Back-to-back misses therefore keep CE_n high for at least SETUP+RECOVER cycles between accesses.
- rsp_ready held high: the response handshake completes on the edge rsp_valid is first seen high; no bubble is added.

## Configuration
- ROPE_PARITY_CHECK_EN defined:
  - parity_err = (rsp_data has an even number of ones), valid while rsp_valid=1.
  - A word failing parity is not written to the buffer, and the buffer is left invalid.
- Undefined:
  - parity_err is tied to 0.
  - Every captured word is buffered.

## Test plan
- Reset, then request 0x00010 with flash_dq=16'h8001, defaults. Required:
  - CE_n low for exactly 120 cycles starting 1 cycle after accept;
  - rsp_valid 121 cycles after accept;
  - rsp_data=16'h8001, rsp_hit=0.
- Repeat the read of 0x00010 after RECOVER. Required: rsp_valid 1 cycle after accept, rsp_hit=1, rsp_data=16'h8001, flash_ce_n stays 1.
- Hold rsp_ready=0 for 10 cycles while the flash model changes flash_dq. Required: rsp_data stays stable; req_ready stays 0 until 2 cycles after the handshake.
- Assert SIM_RST at cycle 50 of an ACCESS. Required: CE_n=OE_n=1 and rsp_valid=0 on that edge. A following read of the same address is a miss.
- With ROPE_PARITY_CHECK_EN, read a word 16'h0003. Required: parity_err=1, and the re-read of the same address is a miss. Word 16'h0007 gives parity_err=0.
